// File: rtl/ib_mul_pkg.sv
// Shared types and helpers for the sequential sliced multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ib_mul_pkg;

    // Controller states: waiting for operands, accumulating digits, holding result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of multiplier digits; guarded so a bad SLICE reaches the elaboration check
    function automatic int digit_count(input int width, input int slice);
        return (slice >= 1) ? (width / slice) : 1;
    endfunction

endpackage

// File: rtl/ib_mul_digit.sv
// Unsigned WIDTH x SLICE partial product of the multiplicand with one multiplier digit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module ib_mul_digit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [SLICE-1:0]       b,
    output logic [WIDTH+SLICE-1:0] p
);

    localparam int PW = WIDTH + SLICE;

    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/ib_mul_seq.sv
// Sequential signed/unsigned multiplier consuming SLICE bits of the multiplier per cycle.
// Latency: o_valid rises N = WIDTH/SLICE cycles after the accepting edge.
// Backpressure: result held in DONE until i_ready; no new operands accepted until back in IDLE.
module ib_mul_seq
    import ib_mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_c
);

    localparam int N  = digit_count(WIDTH, SLICE);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("ib_mul_seq: SLICE must be >= 1 and divide WIDTH");
        end
    endgenerate

    state_t                 state;
    logic [PW-1:0]          acc;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;   // shifted right one digit per BUSY cycle
    logic                   neg;
    logic [WIDTH-1:0]       abs_a;
    logic [WIDTH-1:0]       abs_b;
    logic [WIDTH+SLICE-1:0] prod;
    logic [31:0]            shamt;
    logic [PW-1:0]          acc_next;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        abs_a = (i_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
        abs_b = (i_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;
    end

    ib_mul_digit #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) u_digit (
        .a (mag_a),
        .b (mag_b[SLICE-1:0]),
        .p (prod)
    );

    // Align the current digit product to its weight and add it in
    always_comb begin
        shamt    = 32'(cnt) * 32'(SLICE);
        acc_next = acc + (PW'(prod) << shamt);
    end

    // Controller and datapath state; o_c is only written on completion
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            o_c   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    mag_b <= mag_b >> SLICE;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        o_c   <= neg ? (-acc_next) : acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

endmodule

// File: tb/tb_ib_mul_seq.sv
module tb_ib_mul_seq;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main instance (16,4)
    logic        m_ivld, m_ordy, m_s, m_ovld, m_irdy;
    logic [15:0] m_a, m_b;
    logic [31:0] m_c;

    ib_mul_seq #(.WIDTH(16), .SLICE(4)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_valid(m_ivld), .o_ready(m_ordy),
        .i_signed(m_s), .i_a(m_a), .i_b(m_b), .o_valid(m_ovld),
        .i_ready(m_irdy), .o_c(m_c)
    );

    // Sweep instances sharing handshake controls
    logic        s_ivld, s_irdy, s_s;
    logic        ordy1, ordy2, ordy3, ovld1, ovld2, ovld3;
    logic [7:0]  a1, b1, a2, b2;
    logic [31:0] a3, b3;
    logic [15:0] c1, c2;
    logic [63:0] c3;

    ib_mul_seq #(.WIDTH(8), .SLICE(8)) dut_8_8 (
        .i_clk(clk), .i_nrst(nrst), .i_valid(s_ivld), .o_ready(ordy1),
        .i_signed(s_s), .i_a(a1), .i_b(b1), .o_valid(ovld1),
        .i_ready(s_irdy), .o_c(c1)
    );
    ib_mul_seq #(.WIDTH(8), .SLICE(2)) dut_8_2 (
        .i_clk(clk), .i_nrst(nrst), .i_valid(s_ivld), .o_ready(ordy2),
        .i_signed(s_s), .i_a(a2), .i_b(b2), .o_valid(ovld2),
        .i_ready(s_irdy), .o_c(c2)
    );
    ib_mul_seq #(.WIDTH(32), .SLICE(4)) dut_32_4 (
        .i_clk(clk), .i_nrst(nrst), .i_valid(s_ivld), .o_ready(ordy3),
        .i_signed(s_s), .i_a(a3), .i_b(b3), .o_valid(ovld3),
        .i_ready(s_irdy), .o_c(c3)
    );

    // Reference: interpret operands as integers of width w, multiply, wrap to 2w bits
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input logic sg);
        longint av, bv, p;
        logic [63:0] r;
        av = longint'({32'b0, a});
        bv = longint'({32'b0, b});
        if (sg && a[w-1]) av = av - (longint'(1) << w);
        if (sg && b[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        r = p;
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present operands at a negedge once ready; returns at the negedge after the accept edge
    task automatic m_launch(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        while (!m_ordy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("launch_timeout", 64'd0, 64'd1);
        m_a = a; m_b = b; m_s = s; m_ivld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ivld = 1'b0;
    endtask

    // Edges from the accept edge until o_valid is seen
    task automatic m_wait(output int lat);
        lat = 0;
        while (!m_ovld && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic m_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] exp, input string tag);
        int lat;
        m_launch(a, b, s);
        m_wait(lat);
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check(tag, 64'(m_c), 64'(exp));
        @(negedge clk);
        check({tag, "_hold_vld"}, 64'(m_ovld), 64'd1);
        check({tag, "_hold_c"}, 64'(m_c), 64'(exp));
        m_irdy = 1'b1;
        @(negedge clk);
        m_irdy = 1'b0;
        check({tag, "_released"}, 64'(m_ovld), 64'd0);
    endtask

    task automatic sweep(input logic [7:0] a8, input logic [7:0] b8,
                         input logic [31:0] a32, input logic [31:0] b32,
                         input logic s, input string tag);
        int l1 = -1, l2 = -1, l3 = -1;
        a1 = a8; b1 = b8; a2 = a8; b2 = b8; a3 = a32; b3 = b32; s_s = s;
        s_ivld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_ivld = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ovld1 && l1 < 0) l1 = k;
            if (ovld2 && l2 < 0) l2 = k;
            if (ovld3 && l3 < 0) l3 = k;
            if (l1 >= 0 && l2 >= 0 && l3 >= 0) break;
            @(negedge clk);
        end
        check({tag, "_8x8_lat"}, 64'(l1), 64'd1);
        check({tag, "_8x2_lat"}, 64'(l2), 64'd4);
        check({tag, "_32x4_lat"}, 64'(l3), 64'd8);
        check({tag, "_8x8"}, 64'(c1), ref_mul({24'b0, a8}, {24'b0, b8}, 8, s));
        check({tag, "_8x2"}, 64'(c2), ref_mul({24'b0, a8}, {24'b0, b8}, 8, s));
        check({tag, "_32x4"}, c3, ref_mul(a32, b32, 32, s));
        s_irdy = 1'b1;
        @(negedge clk);
        s_irdy = 1'b0;
    endtask

    initial begin
        int lat, cyc, acc_cnt, last_acc;
        logic [31:0] exp_q[$];
        logic [31:0] exp_bp, exp_next;

        nrst = 1'b0;
        m_ivld = 1'b0; m_irdy = 1'b0; m_s = 1'b0; m_a = '0; m_b = '0;
        s_ivld = 1'b0; s_irdy = 1'b0; s_s = 1'b0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
        #1;
        check("reset_ready", 64'(m_ordy), 64'd1);
        check("reset_valid", 64'(m_ovld), 64'd0);
        check("reset_c", 64'(m_c), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Directed products
        m_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, "unsigned_1234x5678");
        m_op(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, "signed_m1x2");
        m_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "signed_minxmin");
        m_op(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "signed_minxmax");

        // Backpressure in DONE with new operands waiting
        m_launch(16'h00AB, 16'h00CD, 1'b0);
        m_wait(lat);
        check("bp_lat", 64'(lat), 64'd4);
        exp_bp = 32'(ref_mul(32'h00AB, 32'h00CD, 16, 1'b0));
        m_a = 16'hF102; m_b = 16'h0304; m_s = 1'b1; m_ivld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_vld", 64'(m_ovld), 64'd1);
            check("bp_hold_c", 64'(m_c), 64'(exp_bp));
            check("bp_hold_nrdy", 64'(m_ordy), 64'd0);
            @(negedge clk);
        end
        m_irdy = 1'b1;
        @(negedge clk);
        m_irdy = 1'b0;
        check("bp_idle_rdy", 64'(m_ordy), 64'd1);
        check("bp_idle_vld", 64'(m_ovld), 64'd0);
        check("bp_retain_c", 64'(m_c), 64'(exp_bp));
        @(posedge clk);
        @(negedge clk);
        m_ivld = 1'b0;
        check("bp_accepted", 64'(m_ordy), 64'd0);
        m_wait(lat);
        check("bp_next_lat", 64'(lat), 64'd4);
        exp_next = 32'(ref_mul(32'h0000F102, 32'h00000304, 16, 1'b1));
        check("bp_next_c", 64'(m_c), 64'(exp_next));
        m_irdy = 1'b1;
        @(negedge clk);
        m_irdy = 1'b0;

        // Reset two cycles into an operation
        m_launch(16'h1234, 16'h5678, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check("midrst_vld", 64'(m_ovld), 64'd0);
        check("midrst_c", 64'(m_c), 64'd0);
        check("midrst_rdy", 64'(m_ordy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        m_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "after_rst_ffffxffff");

        // Streaming with both handshakes held high
        acc_cnt = 0; cyc = 0; last_acc = -1;
        m_irdy = 1'b1;
        while ((acc_cnt < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            if (m_ovld) begin
                if (exp_q.size() == 0) check("stream_extra", 64'd1, 64'd0);
                else check("stream_prod", 64'(m_c), 64'(exp_q.pop_front()));
            end
            m_a = 16'($urandom);
            m_b = 16'($urandom);
            m_s = 1'($urandom_range(0, 1));
            m_ivld = (acc_cnt < 1000);
            if (m_ordy && m_ivld) begin
                exp_q.push_back(32'(ref_mul({16'b0, m_a}, {16'b0, m_b}, 16, m_s)));
                if (last_acc >= 0) check("stream_spacing", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                acc_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20000) check("stream_timeout", 64'd0, 64'd1);
        m_ivld = 1'b0;
        m_irdy = 1'b0;

        // Parameter sweep
        sweep(8'h12, 8'h56, 32'h12345678, 32'h9ABCDEF0, 1'b0, "sw_unsigned");
        sweep(8'hFF, 8'h02, 32'hFFFFFFFF, 32'h00000002, 1'b1, "sw_m1x2");
        sweep(8'h80, 8'h80, 32'h80000000, 32'h80000000, 1'b1, "sw_minxmin");
        sweep(8'h80, 8'h7F, 32'h80000000, 32'h7FFFFFFF, 1'b1, "sw_minxmax");
        sweep(8'hC3, 8'hA5, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, "sw_signed_mix");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
